// File: rtl/keccak_pkg.sv
// keccak_pkg: shared sizes, state encoding and bit-index rule for the theta datapath
package keccak_pkg;
  localparam int SLICES = 64;
  localparam int ADDR_W = 6;
  localparam int SLICE_W = 25;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    READ  = 3'd2,
    LOAD  = 3'd3,
    APPLY = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;
  // slice bit i holds lane (x,y) with i = 5*y + x
  function automatic int bit_idx(input int x, input int y);
    return 5 * y + x;
  endfunction
endpackage

// File: rtl/theta_apply_cu.sv
// theta_apply_cu: pass sequencer; state register plus Moore strobe decode
//   in : clk, rst (async active-low), start, i_last (25th apply bit), z_last (last slice)
//   out: state to the datapath, ready/done handshake, d_rd/a_rd read strobes, o_wr write strobe
module theta_apply_cu import keccak_pkg::*; (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   i_last,
  input  logic   z_last,
  output state_t state,
  output logic   ready,
  output logic   done,
  output logic   d_rd,
  output logic   a_rd,
  output logic   o_wr
);
  state_t state_q, state_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? INIT : IDLE;
      INIT:    state_d = READ;
      READ:    state_d = LOAD;
      LOAD:    state_d = APPLY;
      APPLY:   state_d = i_last ? WRITE : APPLY;
      WRITE:   state_d = z_last ? DONE : READ;
      default: state_d = IDLE;
    endcase
  end
  assign state = state_q;
  assign ready = state_q == IDLE;
  assign done  = state_q == DONE;
  assign d_rd  = state_q == READ;
  assign a_rd  = state_q == READ;
  assign o_wr  = state_q == WRITE;
endmodule

// File: rtl/theta_apply_dp.sv
// theta_apply_dp: slice/bit counters, D register and the rotating slice shift register
//   in : clk, rst (async active-low), state, d_data (D row), a_data (state slice)
//   out: z slice index, i_last/z_last terminal flags, sreg (theta-applied slice after 25 steps)
module theta_apply_dp import keccak_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  state_t             state,
  input  logic [4:0]         d_data,
  input  logic [SLICE_W-1:0] a_data,
  output logic [ADDR_W-1:0]  z,
  output logic               i_last,
  output logic               z_last,
  output logic [SLICE_W-1:0] sreg
);
  logic [ADDR_W-1:0]  z_q, z_d;
  logic [4:0]         i_q, i_d;
  logic [2:0]         x_q, x_d;
  logic [4:0]         dreg_q, dreg_d;
  logic [SLICE_W-1:0] sreg_q, sreg_d;
  assign z_last = z_q == ADDR_W'(SLICES - 1);
  assign i_last = i_q == 5'd24;
  // each step XORs D[x] into the bit leaving at the LSB and rotates it to the MSB;
  // x tracks the lane column of that bit, so 25 steps touch every bit once and restore order
  always_comb begin
    z_d    = state == INIT ? '0 : (state == WRITE && !z_last) ? z_q + 1'b1 : z_q;
    i_d    = state == LOAD ? '0 : state == APPLY ? i_q + 5'd1 : i_q;
    x_d    = state == LOAD ? '0 : state == APPLY ? (x_q == 3'd4 ? 3'd0 : x_q + 3'd1) : x_q;
    dreg_d = state == LOAD ? d_data : dreg_q;
    sreg_d = state == LOAD ? a_data :
             state == APPLY ? {sreg_q[0] ^ dreg_q[x_q], sreg_q[SLICE_W-1:1]} : sreg_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      z_q    <= '0;
      i_q    <= '0;
      x_q    <= '0;
      dreg_q <= '0;
      sreg_q <= '0;
    end else begin
      z_q    <= z_d;
      i_q    <= i_d;
      x_q    <= x_d;
      dreg_q <= dreg_d;
      sreg_q <= sreg_d;
    end
  assign z    = z_q;
  assign sreg = sreg_q;
endmodule

// File: rtl/theta_apply.sv
// theta_apply: bit-serial Keccak theta apply, A'[x][y][z] = A[x][y][z] ^ D[x][z], one slice per 28 cycles
//   clk, rst (async active-low); start/ready/done pass handshake
//   d_rd/d_addr/d_data: parity memory (sync read); a_rd/a_addr/a_data: state memory (sync read)
//   o_wr/o_addr/o_data: output memory write port
module theta_apply import keccak_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  output logic               done,
  output logic               d_rd,
  output logic [ADDR_W-1:0]  d_addr,
  input  logic [4:0]         d_data,
  output logic               a_rd,
  output logic [ADDR_W-1:0]  a_addr,
  input  logic [SLICE_W-1:0] a_data,
  output logic               o_wr,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [SLICE_W-1:0] o_data
);
  state_t            state;
  logic              i_last, z_last;
  logic [ADDR_W-1:0] z;
  theta_apply_cu u_cu (
    .clk(clk), .rst(rst), .start(start), .i_last(i_last), .z_last(z_last), .state(state),
    .ready(ready), .done(done), .d_rd(d_rd), .a_rd(a_rd), .o_wr(o_wr)
  );
  theta_apply_dp u_dp (
    .clk(clk), .rst(rst), .state(state), .d_data(d_data), .a_data(a_data),
    .z(z), .i_last(i_last), .z_last(z_last), .sreg(o_data)
  );
  assign d_addr = z;
  assign a_addr = z;
  assign o_addr = z;
endmodule

// File: tb/tb_theta_apply.sv
// tb_theta_apply: directed and golden-model checks of theta_apply with behavioural memories
module tb_theta_apply;
  import keccak_pkg::*;
  logic               clk = 0, rst = 0, start = 0;
  logic               ready, done, d_rd, a_rd, o_wr;
  logic [ADDR_W-1:0]  d_addr, a_addr, o_addr;
  logic [4:0]         d_data;
  logic [SLICE_W-1:0] a_data, o_data;
  logic [SLICE_W-1:0] amem [SLICES];
  logic [4:0]         dmem [SLICES];
  logic [SLICE_W-1:0] res  [SLICES];
  logic [SLICE_W-1:0] expv [SLICES];
  bit                 alias_on = 0;
  int                 tests = 0, fails = 0;
  typedef struct { logic [4:0] d; logic [24:0] a; logic [24:0] e; } vec_t;
  vec_t vt [6];

  theta_apply dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
    .d_rd(d_rd), .d_addr(d_addr), .d_data(d_data),
    .a_rd(a_rd), .a_addr(a_addr), .a_data(a_data),
    .o_wr(o_wr), .o_addr(o_addr), .o_data(o_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (d_rd) d_data <= dmem[d_addr];
    if (a_rd) a_data <= amem[a_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [24:0] model(input logic [24:0] a, input logic [4:0] d);
    logic [24:0] r;
    r = a;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[bit_idx(x, y)] = a[bit_idx(x, y)] ^ d[x];
    return r;
  endfunction

  task automatic run_pass(input int pulse_at, input int abort_at,
                          output int lat, output int nwr, output int badaddr);
    int n, extra;
    lat = -1; nwr = 0; badaddr = 0; n = 0;
    for (int z = 0; z < SLICES; z++) res[z] = ~expv[z];
    @(negedge clk); start = 1;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      start = (n == pulse_at);
      if (n == abort_at) begin
        rst = 0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_owr", o_wr, 0);
        extra = 0;
        repeat (3) begin @(negedge clk); if (o_wr) extra++; end
        check("abort_no_writes", extra, 0);
        rst = 1;
        break;
      end
      if (o_wr) begin
        if (o_addr !== ADDR_W'(nwr)) badaddr++;
        res[o_addr] = o_data;
        if (alias_on) amem[o_addr] = o_data;
        nwr++;
      end
      if (done) begin lat = n; break; end
    end
    start = 0;
  endtask

  task automatic check_pass(input string nm, input int lat, input int nwr, input int badaddr);
    check({nm, "_latency"}, lat, 1794);
    check({nm, "_writes"}, nwr, 64);
    check({nm, "_addr_order"}, badaddr, 0);
    for (int z = 0; z < SLICES; z++) check({nm, "_slice"}, res[z], expv[z]);
  endtask

  task automatic fill_random();
    for (int z = 0; z < SLICES; z++) begin
      amem[z] = SLICE_W'($urandom);
      dmem[z] = 5'($urandom);
      expv[z] = model(amem[z], dmem[z]);
    end
  endtask

  initial begin
    int lat, nwr, bad, n, d1, d2, rdy;
    vt[0] = '{5'h00, 25'h1ABCDEF, 25'h1ABCDEF};
    vt[1] = '{5'h01, 25'h0000000, 25'h0108421};
    vt[2] = '{5'h1F, 25'h0000000, 25'h1FFFFFF};
    vt[3] = '{5'h1F, 25'h1FFFFFF, 25'h0000000};
    vt[4] = '{5'h10, 25'h0000000, 25'h1084210};
    vt[5] = '{5'h0A, 25'h0000003, 25'h0A52949};

    rst = 0; start = 1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_d_rd", d_rd, 0);
    check("rst_a_rd", a_rd, 0);
    check("rst_o_wr", o_wr, 0);
    check("rst_o_addr", o_addr, 0);
    check("rst_d_addr", d_addr, 0);
    check("rst_o_data", o_data, 0);
    rst = 1;
    @(negedge clk); check("first_rd_cycle1", d_rd, 0);
    @(negedge clk); check("first_rd_cycle2", {d_rd, a_rd}, 2'b11);
    check("first_rd_addr", a_addr, 0);
    start = 0; rst = 0;
    @(negedge clk); rst = 1;

    for (int v = 0; v < 6; v++) begin
      for (int z = 0; z < SLICES; z++) begin
        amem[z] = vt[v].a; dmem[z] = vt[v].d; expv[z] = vt[v].e;
      end
      run_pass(0, 0, lat, nwr, bad);
      check_pass($sformatf("vec%0d", v), lat, nwr, bad);
    end

    fill_random();
    run_pass(0, 0, lat, nwr, bad);
    check_pass("golden", lat, nwr, bad);

    fill_random();
    alias_on = 1;
    run_pass(290, 0, lat, nwr, bad);
    check_pass("alias_start_pulse", lat, nwr, bad);
    for (int z = 0; z < SLICES; z++) check("alias_mem", amem[z], expv[z]);
    alias_on = 0;

    fill_random();
    run_pass(0, 852, lat, nwr, bad);
    check("abort_writes_before", nwr, 30);
    check("abort_no_done", lat, 32'hFFFFFFFF);
    @(negedge clk); check("abort_idle", ready, 1);
    fill_random();
    run_pass(0, 0, lat, nwr, bad);
    check_pass("after_abort", lat, nwr, bad);

    fill_random();
    @(negedge clk); start = 1;
    n = 0; d1 = -1; d2 = -1; rdy = 0;
    while (n < 5000 && d2 < 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (d1 < 0) d1 = n; else d2 = n;
      end else if (d1 >= 0 && ready) rdy++;
    end
    start = 0;
    check("b2b_first_done", d1, 1794);
    check("b2b_gap", d2 - d1, 1795);
    check("b2b_ready_cycles", rdy, 1);
    repeat (3) @(negedge clk);
    check("b2b_stops", {ready, d_rd}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
